// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first, behind a start/ready/valid handshake.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             valid
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Single full-subtractor cell working on the current LSBs of the operand shift registers.
    always_comb begin
        a_bit   = a_sr[0];
        b_bit   = b_sr[0];
        d_bit   = a_bit ^ b_bit ^ br;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        br     <= bin;
                        res_sr <= '0;
                        cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    // The last bit is still in flight, so the result is assembled from the cell output directly.
                    if (cnt == LAST) begin
                        diff <= {d_bit, res_sr[WIDTH-1:1]};
                        bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf  <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=4 directed + exhaustive, WIDTH=8 random,
// checked every cycle against an arithmetic model; ovf is also checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, bin4, start8, bin8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;

    logic       ready4, valid4, bout4;
    logic [3:0] diff4;
    logic       ready8, valid8, bout8;
    logic [7:0] diff8;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf4, ovf8;
`endif

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .ready(ready4), .diff(diff4), .bout(bout4), .valid(valid4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .ready(ready8), .diff(diff8), .bout(bout8), .valid(valid8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // Transaction-level model: phase 0 is idle, 1..w busy, w+1 is the result cycle.
    typedef struct {
        int phase;
        int la, lb, lbin;
        int diff;
        bit bout, valid, ovf;
    } model_t;

    model_t m4 = '{default: 0};
    model_t m8 = '{default: 0};

    function automatic model_t step(model_t m, int w, bit rst, bit st, int a, int b, int bi);
        model_t n = m;
        int sa, sb, t;
        if (!rst) begin
            n.phase = 0; n.diff = 0; n.bout = 0; n.valid = 0; n.ovf = 0;
        end else if (m.phase == 0) begin
            if (st) begin
                n.phase = 1; n.la = a; n.lb = b; n.lbin = bi;
            end
        end else if (m.phase < w) begin
            n.phase = m.phase + 1;
        end else if (m.phase == w) begin
            n.phase = w + 1;
            n.valid = 1;
            n.diff  = (m.la - m.lb - m.lbin + (1 << w)) % (1 << w);
            n.bout  = (m.la < m.lb + m.lbin);
            sa = (m.la >= (1 << (w - 1))) ? m.la - (1 << w) : m.la;
            sb = (m.lb >= (1 << (w - 1))) ? m.lb - (1 << w) : m.lb;
            t  = sa - sb - m.lbin;
            n.ovf = (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
        end else begin
            n.phase = 0;
            n.valid = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m4 = step(m4, 4, rst_n, start4, int'(a4), int'(b4), int'(bin4));
        m8 = step(m8, 8, rst_n, start8, int'(a8), int'(b8), int'(bin8));
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("ready4", ready4, (m4.phase == 0));
            chk("valid4", valid4, m4.valid);
            chk("diff4",  diff4,  m4.diff);
            chk("bout4",  bout4,  m4.bout);
            chk("ready8", ready8, (m8.phase == 0));
            chk("valid8", valid8, m8.valid);
            chk("diff8",  diff8,  m8.diff);
            chk("bout8",  bout8,  m8.bout);
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf4", ovf4, m4.ovf);
            chk("ovf8", ovf8, m8.ovf);
`endif
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge right after the accept edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic bi);
        a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic waitValid4(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (valid4 === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++; errors++;
            $display("[TB] FAIL %s_timeout got no valid want valid within 20 cycles", name);
        end
    endtask

    // Literal expectations pin both the DUT and the model.
    task automatic checkOutput(input string name, input logic [3:0] ed, input logic eb, input logic eo);
        chk({name, "_diff"}, diff4, ed);
        chk({name, "_bout"}, bout4, eb);
        chk({name, "_model_diff"}, m4.diff, ed);
        chk({name, "_model_bout"}, m4.bout, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk({name, "_ovf"}, ovf4, eo);
        chk({name, "_model_ovf"}, m4.ovf, eo);
`else
        if (eo === 1'bx) $display("[TB] unreachable");
`endif
    endtask

    task automatic runOp4(input logic [3:0] a, input logic [3:0] b, input logic bi, input bit lit,
                          input logic [3:0] ed, input logic eb, input logic eo, input string name);
        int n;
        applyStimulus(a, b, bi);
        waitValid4(name, n);
        if (lit) begin
            checkOutput(name, ed, eb, eo);
            chk({name, "_latency"}, n, 4);
        end
        @(negedge clk);
    endtask

    task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        bit seen = 1'b0;
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (valid8 === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL w8_timeout got no valid want valid within 30 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  saw;
        rst_n = 1'b0;
        start4 = 1'b0; start8 = 1'b0; bin4 = 1'b0; bin8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checking = 1'b1;
        chk("rst_ready", ready4, 1);
        chk("rst_valid", valid4, 0);
        chk("rst_diff",  diff4,  0);
        chk("rst_bout",  bout4,  0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_ready", ready4, 1);
        chk("idle_diff",  diff4,  0);

        runOp4(4'd9, 4'd3, 1'b0, 1, 4'd6,  1'b0, 1'b1, "basic");
        chk("basic_ready_after", ready4, 1);
        runOp4(4'd3, 4'd9, 1'b0, 1, 4'hA,  1'b1, 1'b1, "borrow1");
        runOp4(4'd0, 4'd0, 1'b1, 1, 4'hF,  1'b1, 1'b0, "borrow2");
        runOp4(4'd7, 4'hF, 1'b0, 1, 4'd8,  1'b1, 1'b1, "ovf1");
        runOp4(4'hF, 4'h8, 1'b0, 1, 4'd7,  1'b0, 1'b0, "ovf2");

        // Back-to-back with start held high and operands churning while busy.
        a4 = 4'd5; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        chk("b2b_busy", ready4, 0);
        saw = 1'b0;
        for (int i = 0; i < 20 && !saw; i++) begin
            a4 = 4'(i * 7 + 3); b4 = 4'(i * 5 + 1);
            @(negedge clk);
            if (valid4 === 1'b1) saw = 1'b1;
        end
        if (!saw) begin
            checks++; errors++;
            $display("[TB] FAIL b2b_timeout got no valid want valid");
        end
        checkOutput("b2b_first", 4'd4, 1'b0, 1'b0);
        a4 = 4'd11; b4 = 4'd2;
        @(negedge clk);
        chk("b2b_idle_after_done", ready4, 1);
        @(negedge clk);
        chk("b2b_second_accepted", ready4, 0);
        start4 = 1'b0;
        a4 = 4'd0; b4 = 4'd15;
        waitValid4("b2b_second", n);
        checkOutput("b2b_second", 4'd9, 1'b0, 1'b0);
        @(negedge clk);

        // Reset in the middle of an operation.
        applyStimulus(4'd12, 4'd5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready4, 1);
        chk("abort_valid", valid4, 0);
        chk("abort_diff",  diff4,  0);
        chk("abort_bout",  bout4,  0);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (valid4 !== 1'b0) saw = 1'b1;
        end
        chk("abort_novalid", saw, 0);
        runOp4(4'd12, 4'd5, 1'b0, 1, 4'd7, 1'b0, 1'b1, "after_abort");

        // Exhaustive WIDTH=4 sweep; the compare process checks every cycle.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    runOp4(4'(a), 4'(b), 1'(bi), 0, 4'd0, 1'b0, 1'b0, "sweep");

        // WIDTH=8: one literal vector then random operands.
        runOp8(8'h10, 8'h01, 1'b0);
        chk("w8_lit_diff", diff8, 8'h0F);
        chk("w8_lit_bout", bout8, 0);
        runOp8(8'h00, 8'h01, 1'b1);
        chk("w8_lit2_diff", diff8, 8'hFE);
        chk("w8_lit2_bout", bout8, 1);
        for (int i = 0; i < 100; i++)
            runOp8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
